// File: rtl/branch_predict_unit_if.sv
// Fetch/resolve bus between the pipeline and the branch predictor.
// Optional stats outputs are present only when BRANCH_STATS_EN is defined.
interface branch_predict_unit_if #(
    parameter int PC_WIDTH = 16
);
    logic                fetch_valid;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                pred_valid;
    logic                pred_taken;
    logic                res_valid;
    logic [PC_WIDTH-1:0] res_pc;
    logic [2:0]          res_jump_type;
    logic                res_pred_taken;
    logic                zero_flag;
    logic                sign_flag;
    logic                carry_flag;
    logic                overflow_flag;
    logic                res_taken;
    logic                mispredict;
    logic                shadow_busy;
`ifdef BRANCH_STATS_EN
    logic [15:0]         branch_count;
    logic [15:0]         miss_count;
`endif

    modport master (
        output fetch_valid, fetch_pc,
        output res_valid, res_pc, res_jump_type, res_pred_taken,
        output zero_flag, sign_flag, carry_flag, overflow_flag,
`ifdef BRANCH_STATS_EN
        input  branch_count, miss_count,
`endif
        input  pred_valid, pred_taken, res_taken, mispredict, shadow_busy
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  res_valid, res_pc, res_jump_type, res_pred_taken,
        input  zero_flag, sign_flag, carry_flag, overflow_flag,
`ifdef BRANCH_STATS_EN
        output branch_count, miss_count,
`endif
        output pred_valid, pred_taken, res_taken, mispredict, shadow_busy
    );
endinterface

// File: rtl/branch_predict_unit.sv
// 2-bit saturating-counter branch predictor with a post-mispredict resolve shadow.
// Define BRANCH_STATS_EN to add saturating branch/miss counters on the interface.
//
// state  | meaning
// IDLE   | resolves accepted
// SHADOW | resolves ignored for SHADOW_CYCLES cycles after a mispredict
module branch_predict_unit #(
    parameter int PC_WIDTH      = 16,
    parameter int BHT_DEPTH     = 16,
    parameter int SHADOW_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_predict_unit_if.slave bp
);
    localparam int IDX = $clog2(BHT_DEPTH);
    localparam logic [3:0] SHADOW_LOAD = 4'(SHADOW_CYCLES);

    typedef enum logic {IDLE, SHADOW} state_t;

    state_t     state;
    logic [3:0] shadow_cnt;
    logic [1:0] bht [BHT_DEPTH];

    logic pred_valid, pred_taken, res_taken, mispredict, shadow_busy;

    logic [IDX-1:0] fetch_idx, res_idx;
    logic           taken, accept, update, miss_now;

    assign fetch_idx = bp.fetch_pc[IDX-1:0];
    assign res_idx   = bp.res_pc[IDX-1:0];

    always_comb begin
        taken = 1'b0;
        case (bp.res_jump_type)
            3'b000: taken = 1'b0;
            3'b001: taken = bp.zero_flag;
            3'b010: taken = bp.carry_flag;
            3'b011: taken = ~bp.carry_flag & ~bp.zero_flag;
            3'b100: taken = bp.sign_flag ^ bp.overflow_flag;
            3'b101: taken = ~(bp.sign_flag ^ bp.overflow_flag) & ~bp.zero_flag;
            3'b110: taken = ~bp.zero_flag;
            3'b111: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Type 000 is accepted (res_taken=0) but never trains or mispredicts.
    assign accept   = bp.res_valid & ~shadow_busy;
    assign update   = accept & (bp.res_jump_type != 3'b000);
    assign miss_now = update & (taken != bp.res_pred_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            res_taken   <= 1'b0;
            mispredict  <= 1'b0;
            shadow_busy <= 1'b0;
            state       <= IDLE;
            shadow_cnt  <= 4'd0;
        end else begin
            // Lookup reads the pre-update value when it collides with a training write.
            pred_valid <= bp.fetch_valid;
            if (bp.fetch_valid) pred_taken <= bht[fetch_idx][1];

            if (accept) res_taken <= taken;
            mispredict <= miss_now;

            if (update) begin
                if (taken && bht[res_idx] != 2'b11)
                    bht[res_idx] <= bht[res_idx] + 2'd1;
                else if (!taken && bht[res_idx] != 2'b00)
                    bht[res_idx] <= bht[res_idx] - 2'd1;
            end

            case (state)
                IDLE: begin
                    if (miss_now && SHADOW_CYCLES > 0) begin
                        state       <= SHADOW;
                        shadow_cnt  <= SHADOW_LOAD;
                        shadow_busy <= 1'b1;
                    end
                end
                SHADOW: begin
                    if (shadow_cnt <= 4'd1) begin
                        state       <= IDLE;
                        shadow_cnt  <= 4'd0;
                        shadow_busy <= 1'b0;
                    end else begin
                        shadow_cnt <= shadow_cnt - 4'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    shadow_cnt  <= 4'd0;
                    shadow_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bp.pred_valid  = pred_valid;
    assign bp.pred_taken  = pred_taken;
    assign bp.res_taken   = res_taken;
    assign bp.mispredict  = mispredict;
    assign bp.shadow_busy = shadow_busy;

`ifdef BRANCH_STATS_EN
    logic [15:0] branch_count, miss_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count <= 16'd0;
            miss_count   <= 16'd0;
        end else begin
            if (update && branch_count != 16'hFFFF) branch_count <= branch_count + 16'd1;
            if (miss_now && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end

    assign bp.branch_count = branch_count;
    assign bp.miss_count   = miss_count;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit at default parameters.
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    branch_predict_unit_if #(.PC_WIDTH(16)) bp_if ();

    branch_predict_unit #(
        .PC_WIDTH(16), .BHT_DEPTH(16), .SHADOW_CYCLES(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic [15:0] pc, input logic [2:0] jt, input logic pt,
                           input logic z, input logic s, input logic c, input logic v);
        bp_if.res_valid      = 1'b1;
        bp_if.res_pc         = pc;
        bp_if.res_jump_type  = jt;
        bp_if.res_pred_taken = pt;
        bp_if.zero_flag      = z;
        bp_if.sign_flag      = s;
        bp_if.carry_flag     = c;
        bp_if.overflow_flag  = v;
    endtask

    task automatic fetch(input logic fv, input logic [15:0] pc);
        bp_if.fetch_valid = fv;
        bp_if.fetch_pc    = pc;
    endtask

    function automatic logic exp_taken(input logic [2:0] jt, input logic z, input logic s,
                                       input logic c, input logic v);
        case (jt)
            3'd0: return 1'b0;
            3'd1: return z;
            3'd2: return c;
            3'd3: return !c && !z;
            3'd4: return s != v;
            3'd5: return (s == v) && !z;
            3'd6: return !z;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        logic [3:0] f;
        logic       e;
        fetch(1'b0, 16'h0);
        set_res(16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bp_if.res_valid = 1'b0;

        #12;
        chk("rst_pred_valid", bp_if.pred_valid, 0);
        chk("rst_pred_taken", bp_if.pred_taken, 0);
        chk("rst_res_taken", bp_if.res_taken, 0);
        chk("rst_mispredict", bp_if.mispredict, 0);
        chk("rst_shadow_busy", bp_if.shadow_busy, 0);
        @(negedge clk) rst_n = 1'b1;

        // first lookup after reset: weakly not taken
        fetch(1'b1, 16'h0003);
        step();
        chk("lk3_valid", bp_if.pred_valid, 1);
        chk("lk3_taken", bp_if.pred_taken, 0);
        fetch(1'b0, 16'h0003);
        step();
        chk("lk_idle_valid", bp_if.pred_valid, 0);
        chk("lk_idle_hold", bp_if.pred_taken, 0);

        // train pc 3 up to 11, read through alias 0x13
        set_res(16'h0003, 3'd7, 1'b1, 0, 0, 0, 0);
        step();
        chk("tr1_res_taken", bp_if.res_taken, 1);
        chk("tr1_mis", bp_if.mispredict, 0);
        step();
        chk("tr2_mis", bp_if.mispredict, 0);
        bp_if.res_valid = 1'b0;
        fetch(1'b1, 16'h0013);
        step();
        chk("alias13_taken", bp_if.pred_taken, 1);
        fetch(1'b0, 16'h0);

        // mispredict with shadow; resolves inside shadow ignored
        set_res(16'h0007, 3'd5, 1'b0, 0, 1, 0, 1);
        step();
        chk("mp_res_taken", bp_if.res_taken, 1);
        chk("mp_pulse", bp_if.mispredict, 1);
        chk("mp_busy0", bp_if.shadow_busy, 1);
        set_res(16'h0007, 3'd3, 1'b0, 0, 0, 1, 0);
        step();
        chk("mp_pulse_end", bp_if.mispredict, 0);
        chk("mp_busy1", bp_if.shadow_busy, 1);
        chk("mp_hold1", bp_if.res_taken, 1);
        step();
        chk("mp_busy_end", bp_if.shadow_busy, 0);
        chk("mp_hold2", bp_if.res_taken, 1);
        chk("mp_no_mis", bp_if.mispredict, 0);
        bp_if.res_valid = 1'b0;
        fetch(1'b1, 16'h0007);
        step();
        chk("shadow_no_upd", bp_if.pred_taken, 1);

        // same-cycle lookup and update on index 5
        set_res(16'h0005, 3'd7, 1'b1, 0, 0, 0, 0);
        fetch(1'b1, 16'h0005);
        step();
        chk("coll_pre", bp_if.pred_taken, 0);
        chk("coll_res", bp_if.res_taken, 1);
        bp_if.res_valid = 1'b0;
        step();
        chk("coll_post", bp_if.pred_taken, 1);
        fetch(1'b0, 16'h0);

        // type 000 trains nothing and never mispredicts
        set_res(16'h000A, 3'd7, 1'b1, 0, 0, 0, 0);
        step();
        set_res(16'h000A, 3'd0, 1'b1, 0, 0, 0, 0);
        step();
        chk("t0_res_taken", bp_if.res_taken, 0);
        chk("t0_mis", bp_if.mispredict, 0);
        chk("t0_busy", bp_if.shadow_busy, 0);
        step();
        chk("t0_mis2", bp_if.mispredict, 0);
        bp_if.res_valid = 1'b0;
        fetch(1'b1, 16'h000A);
        step();
        chk("t0_no_upd", bp_if.pred_taken, 1);
        fetch(1'b0, 16'h0);

        // saturation at 00 on pc 9
        set_res(16'h0009, 3'd6, 1'b0, 1, 0, 0, 0);
        step();
        step();
        set_res(16'h0009, 3'd7, 1'b1, 0, 0, 0, 0);
        step();
        bp_if.res_valid = 1'b0;
        fetch(1'b1, 16'h0009);
        step();
        chk("sat00", bp_if.pred_taken, 0);
        fetch(1'b0, 16'h0);

        // condition-code sweep, back-to-back, predicted correctly
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 16; k++) begin
                f = 4'(k);
                e = exp_taken(3'(t), f[3], f[2], f[1], f[0]);
                set_res(16'h000E, 3'(t), e, f[3], f[2], f[1], f[0]);
                step();
                chk($sformatf("sweep_t%0d_f%0h", t, k), bp_if.res_taken, 32'(e));
                chk($sformatf("sweep_mis_t%0d_f%0h", t, k), bp_if.mispredict, 0);
            end
        end
        bp_if.res_valid = 1'b0;
        step();

        // reset in the middle of a shadow
        set_res(16'h0002, 3'd7, 1'b0, 0, 0, 0, 0);
        step();
        chk("rs_busy_pre", bp_if.shadow_busy, 1);
        bp_if.res_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rs_busy", bp_if.shadow_busy, 0);
        chk("rs_mis", bp_if.mispredict, 0);
        chk("rs_res_taken", bp_if.res_taken, 0);
`ifdef BRANCH_STATS_EN
        chk("rs_branch_count", bp_if.branch_count, 0);
        chk("rs_miss_count", bp_if.miss_count, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        set_res(16'h0002, 3'd7, 1'b1, 0, 0, 0, 0);
        step();
        chk("rs_first_accept", bp_if.res_taken, 1);
`ifdef BRANCH_STATS_EN
        chk("rs_branch_count1", bp_if.branch_count, 1);
`endif
        bp_if.res_valid = 1'b0;
        fetch(1'b1, 16'h0003);
        step();
        chk("rs_bht3", bp_if.pred_taken, 0);
        fetch(1'b1, 16'h0007);
        step();
        chk("rs_bht7", bp_if.pred_taken, 0);
        fetch(1'b1, 16'h000A);
        step();
        chk("rs_bhtA", bp_if.pred_taken, 0);
        fetch(1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter PC_WIDTH, default 16, SHALL set the program-counter width in bits.
REQ-002 Parameter BHT_DEPTH, default 16, SHALL set the number of 2-bit counters; it SHALL be a power of two, at least 2; IDX = log2(BHT_DEPTH).
REQ-003 Parameter SHADOW_CYCLES, default 2, range 0..15, SHALL set the number of cycles resolve inputs are ignored after a mispredict.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 fetch_valid  in  1  lookup request.
REQ-007 fetch_pc  in  PC_WIDTH  lookup address.
REQ-008 pred_valid  out  1  lookup result valid (registered).
REQ-009 pred_taken  out  1  predicted direction (registered).
REQ-010 res_valid  in  1  branch resolving this cycle.
REQ-011 res_pc  in  PC_WIDTH  address of the resolving branch.
REQ-012 res_jump_type  in  3  condition code of the resolving branch.
REQ-013 res_pred_taken  in  1  prediction originally issued for this branch.
REQ-014 zero_flag, sign_flag, carry_flag, overflow_flag  in  1 each  ALU flags for the resolving branch.
REQ-015 res_taken  out  1  resolved direction (registered).
REQ-016 mispredict  out  1  one-cycle pulse on a wrong prediction (registered).
REQ-017 shadow_busy  out  1  high while resolve inputs are being ignored.

Function
REQ-018 BHT index SHALL be pc[IDX-1:0] for both lookup and update.
REQ-019 Lookup SHALL have 1-cycle latency: pred_valid equals fetch_valid delayed one cycle; pred_taken equals counter[1] of the indexed entry when fetch_valid was sampled high, and holds otherwise.
REQ-020 Taken SHALL be computed from res_jump_type as follows:
- 000 never taken.
- 001 Z.
- 010 C.
- 011 !C & !Z.
- 100 S != V.
- 101 S == V & !Z.
- 110 !Z.
- 111 always taken.
REQ-021 An accepted resolve (res_valid & !shadow_busy) with a type other than 000 SHALL update the indexed counter: saturating increment if taken, saturating decrement if not taken; counters saturate at 11 and 00.
REQ-022 A type-000 resolve SHALL update no counter, and SHALL NOT assert mispredict or start a shadow.
REQ-023 On an accepted resolve, res_taken SHALL take the taken value and mispredict SHALL be asserted for exactly the next cycle if taken != res_pred_taken; otherwise both SHALL be 0 the next cycle.
REQ-024 A lookup and an update to the same index in the same cycle SHALL return the pre-update counter value; the update SHALL still be applied.
REQ-025 The shadow FSM SHALL have two states:
- IDLE: a mispredict with SHADOW_CYCLES>0 SHALL move it to SHADOW with its counter loaded to SHADOW_CYCLES.
- SHADOW: the counter decrements each cycle; the FSM returns to IDLE on the cycle the counter reaches 0.
REQ-026 shadow_busy SHALL be 1 exactly while the FSM is in SHADOW; res_valid SHALL be ignored entirely (no update, no outputs change) during SHADOW.
REQ-027 With SHADOW_CYCLES=0, the FSM SHALL stay in IDLE and back-to-back resolves SHALL all be accepted.
REQ-028 Lookups SHALL be serviced in every state, including SHADOW.

Reset
REQ-029 Asserting rst_n low SHALL immediately reset, asynchronously:
- every counter to 01 (weakly not taken);
- pred_valid, pred_taken, res_taken, mispredict and shadow_busy to 0;
- the FSM to IDLE with its counter at 0.
REQ-030 Reset mid-shadow SHALL abort the shadow; the first resolve after rst_n rises SHALL be accepted.

Configuration
REQ-031 With macro BRANCH_STATS_EN defined, the block SHALL add outputs branch_count[15:0] and miss_count[15:0]:
- branch_count increments on each accepted non-000 resolve;
- miss_count increments on each mispredict;
- both saturate at 16'hFFFF and reset to 0.
REQ-032 With BRANCH_STATS_EN undefined, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset then fetch_pc=0x0003 -> pred_valid=1 and pred_taken=0 the next cycle.
REQ-034 Two accepted resolves at pc=0x0003, type 111, res_pred_taken=1 -> counter at 11; a lookup of 0x0013 (aliasing, BHT_DEPTH=16) returns pred_taken=1; no mispredict.
REQ-035 Resolve type 101 with S=1, V=1, Z=0 and res_pred_taken=0 -> res_taken=1, mispredict pulse of 1 cycle, shadow_busy high for 2 cycles, and a res_valid during those 2 cycles leaves the counters unchanged.
REQ-036 Same-cycle lookup and update of index 5 when its counter is 01 and the resolve is taken -> pred_taken=0; a following lookup of index 5 returns 1.
REQ-037 rst_n low during SHADOW -> shadow_busy=0 at once and all counters at 01; with BRANCH_STATS_EN, both stats counters read 0.
REQ-038 Sweep all 8 jump types against all 16 flag combinations -> res_taken matches the REQ-020 table in every case.
